fft_256_reorder: RTL and testbench

- Output reorder buffer for the 256-point pipelined FFT.
- The FFT core emits each frame in bit-reversed index order. This block is the reader of that stream: it collects one frame and replays it in natural order 0..255.
- Sits between the last FFT stage and downstream consumers.
- Ping-pong double buffer, so one frame is written while the previous frame is read, sustaining one sample per cycle.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_reorder_bank.sv | 37 +++
 rtl/fft_256_reorder.sv | 220 ++++++++++++++++++++++
 tb/tb_fft_256_reorder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and index helper for the 256-point FFT datapath.
package fft_pkg;

  localparam int FFT_LOG2N = 8;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int FFT_DW    = 16;

  // One complex sample, real part in the upper half.
  typedef struct packed {
    logic signed [FFT_DW-1:0] r;
    logic signed [FFT_DW-1:0] i;
  } fft_sample_t;

  // Read-side sequencing states of the reorder buffer.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rd_state_t;

  // Reverse all FFT_LOG2N bits of a sample index.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] rev;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      rev[b] = idx[FFT_LOG2N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of sample storage: synchronous write port, registered read port.
// The read register only updates when rd_en is high, so it doubles as a
// holding (prefetch) register for the last word read.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = 2 * FFT_DW
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  localparam int DEPTH = 1 << LOG2N;

  logic [W-1:0] mem [0:DEPTH-1];

  // Store an incoming sample at its reordered address.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; the output holds its value while rd_en is low.
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_256_reorder.sv
// Output reorder buffer for the 256-point FFT: collects a bit-reversed frame
// into one bank of a ping-pong pair and replays it in natural order.
module fft_256_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 frame_err
);

  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

  // Bank bookkeeping
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic             iss_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;

  // Write side
  logic             accept;
  logic             wr_en;
  logic             wr_last;
  logic [LOG2N-1:0] wr_addr;
  logic [2*DW-1:0]  wr_data;

  // Read side
  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             iss_en;
  logic [LOG2N-1:0] iss_addr;
  logic             can_issue;
  logic             pf_valid;
  logic             pf_sof;
  logic             pf_eof;
  logic             pf_bank;
  logic             pf_to_out;
  logic [2*DW-1:0]  q0;
  logic [2*DW-1:0]  q1;
  logic [2*DW-1:0]  pf_data;
  logic             rd_release;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  // A sample is stored if it starts a frame or continues one already started.
  assign wr_en    = accept && (in_sof || (wr_cnt != '0));
  assign wr_addr  = in_sof ? '0 : bitrev(wr_cnt);
  assign wr_last  = wr_en && !in_sof && (wr_cnt == LAST);
  assign wr_data  = {in_r, in_i};

  // The prefetch slot feeds the output register whenever that register is free
  // or being drained; a new RAM read may be issued whenever the slot will be empty.
  assign pf_data    = pf_bank ? q1 : q0;
  assign pf_to_out  = pf_valid && (!out_valid || out_ready);
  assign can_issue  = !pf_valid || pf_to_out;
  assign rd_release = out_valid && out_ready && out_eof;

  fft_reorder_bank #(.LOG2N(LOG2N), .W(2*DW)) u_bank0 (
    .CLK     (CLK),
    .wr_en   (wr_en && (wr_bank == 1'b0)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (iss_en && (iss_bank == 1'b0)),
    .rd_addr (iss_addr),
    .rd_data (q0)
  );

  fft_reorder_bank #(.LOG2N(LOG2N), .W(2*DW)) u_bank1 (
    .CLK     (CLK),
    .wr_en   (wr_en && (wr_bank == 1'b1)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (iss_en && (iss_bank == 1'b1)),
    .rd_addr (iss_addr),
    .rd_data (q1)
  );

  // Write counter, bank toggle on frame completion, and misframe pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && in_sof && (wr_cnt != '0);
      if (wr_en) begin
        if (in_sof) begin
          wr_cnt <= LOG2N'(1);
        end else if (wr_cnt == LAST) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Full flags are set by the writer and cleared by the end-of-frame handshake;
  // the two never target the same bank, so both may happen in one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
    end else begin
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_release) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Read sequencer: PRIME fetches index 0, STREAM walks the rest; after the last
  // read it chains straight into the other bank if that frame is already complete.
  always_comb begin
    state_nxt = state;
    iss_en    = 1'b0;
    iss_addr  = rd_cnt;
    case (state)
      RD_IDLE: begin
        if (full[iss_bank]) begin
          state_nxt = RD_PRIME;
        end
      end
      RD_PRIME: begin
        if (can_issue) begin
          iss_en    = 1'b1;
          iss_addr  = '0;
          state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (can_issue) begin
          iss_en = 1'b1;
          if (rd_cnt == LAST) begin
            state_nxt = full[~iss_bank] ? RD_PRIME : RD_IDLE;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Sequencer state, read address counter and the bank being read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RD_IDLE;
      rd_cnt   <= '0;
      iss_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (iss_en) begin
        if (state == RD_PRIME) begin
          rd_cnt <= LOG2N'(1);
        end else if (rd_cnt == LAST) begin
          rd_cnt   <= '0;
          iss_bank <= ~iss_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Prefetch slot tags: track which bank holds the fetched word and its frame position.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pf_valid <= 1'b0;
      pf_sof   <= 1'b0;
      pf_eof   <= 1'b0;
      pf_bank  <= 1'b0;
    end else if (iss_en) begin
      pf_valid <= 1'b1;
      pf_sof   <= (iss_addr == '0);
      pf_eof   <= (iss_addr == LAST);
      pf_bank  <= iss_bank;
    end else if (pf_to_out) begin
      pf_valid <= 1'b0;
    end
  end

  // Output register: loads from the prefetch slot, holds while stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else if (pf_to_out) begin
      out_valid      <= 1'b1;
      out_sof        <= pf_sof;
      out_eof        <= pf_eof;
      {out_r, out_i} <= pf_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_256_reorder.sv
// Self-checking bench for fft_256_reorder: random and patterned frames checked
// against a frame-level reference model held in queues.
module tb_fft_256_reorder;
  import fft_pkg::*;

  localparam int N = FFT_N;

  logic                     CLK = 1'b0;
  logic                     RST_N = 1'b0;
  logic                     in_valid, in_ready, in_sof;
  logic signed [FFT_DW-1:0] in_r, in_i;
  logic                     out_valid, out_ready, out_sof, out_eof, frame_err;
  logic signed [FFT_DW-1:0] out_r, out_i;

  typedef struct packed {
    logic                     sof;
    logic                     eof;
    logic signed [FFT_DW-1:0] r;
    logic signed [FFT_DW-1:0] i;
  } beat_t;

  typedef struct {
    logic                     sof;
    logic signed [FFT_DW-1:0] r;
    logic signed [FFT_DW-1:0] i;
  } src_t;

  beat_t       exp_q[$];
  src_t        src_q[$];
  fft_sample_t m_frame [N];
  int          m_cnt, m_done;
  int          rdy_pct, cyc;
  int          total, bad;
  logic        s_acc, s_hs, s_ovalid, s_iready, s_err;
  beat_t       s_out;

  fft_256_reorder dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .out_r(out_r), .out_i(out_i), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  // Index reversal computed arithmetically, independent of the design's helper.
  function automatic int ref_rev(input int x);
    int r;
    r = 0;
    for (int b = 0; b < FFT_LOG2N; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  // Frame model: input position k carries natural index rev(k); complete frames
  // are queued as the natural-order beats the consumer should see.
  task automatic model_accept(input src_t s);
    bit keep;
    keep = 1'b1;
    if (s.sof) m_cnt = 0;
    else if (m_cnt == 0) keep = 1'b0;
    if (keep) begin
      m_frame[ref_rev(m_cnt)] = {s.r, s.i};
      m_cnt++;
      if (m_cnt == N) begin
        for (int n = 0; n < N; n++)
          exp_q.push_back({n == 0, n == N-1, m_frame[n].r, m_frame[n].i});
        m_cnt = 0;
        m_done++;
      end
    end
  endtask

  task automatic push_frame(input bit det, input int len);
    for (int k = 0; k < len; k++) begin
      src_t s;
      s.sof = (k == 0);
      if (det) begin
        s.r = FFT_DW'(ref_rev(k));
        s.i = FFT_DW'(-ref_rev(k));
      end else begin
        s.r = FFT_DW'($urandom);
        s.i = FFT_DW'($urandom);
      end
      src_q.push_back(s);
    end
  endtask

  // One clock: drive the source head and out_ready, sample at the falling edge,
  // feed accepted samples to the model, return just after the next rising edge.
  task automatic run_cycle();
    if (src_q.size() > 0) begin
      in_valid = 1'b1; in_sof = src_q[0].sof; in_r = src_q[0].r; in_i = src_q[0].i;
    end else begin
      in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0;
    end
    out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge CLK);
    s_acc    = in_valid && in_ready;
    s_hs     = out_valid && out_ready;
    s_ovalid = out_valid;
    s_iready = in_ready;
    s_err    = frame_err;
    s_out    = {out_sof, out_eof, out_r, out_i};
    if (s_acc) begin
      model_accept(src_q[0]);
      void'(src_q.pop_front());
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({out_valid, out_sof, out_eof, frame_err} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags: got=%b want=0000", {out_valid, out_sof, out_eof, frame_err});
    end
    total++;
    if ({out_r, out_i} !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_data: got=%h want=00000000", {out_r, out_i});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_in_ready: got=%b want=1", in_ready);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    m_cnt = 0; m_done = 0; cyc = 0;
  endtask

  task automatic test_single_frame();
    int n, guard, c, last_acc_edge, first_v, drops;
    beat_t want, dummy;
    rdy_pct = 100; n = 0; guard = 0; last_acc_edge = -1; first_v = -1; drops = 0;
    push_frame(1'b1, N);
    while (n < N && guard < 2000) begin
      c = cyc;
      run_cycle();
      guard++;
      if (!s_iready) drops++;
      if (s_acc && src_q.size() == 0) last_acc_edge = c + 1;
      if (s_ovalid && first_v < 0) first_v = c;
      if (s_hs) begin
        want = {n == 0, n == N-1, FFT_DW'(n), FFT_DW'(-n)};
        total++;
        if (s_out !== want) begin
          bad++; $display("[TB] FAIL single_beat[%0d]: got=%h want=%h", n, s_out, want);
        end
        if (exp_q.size() > 0) dummy = exp_q.pop_front();
        n++;
      end
    end
    total++;
    if (n != N) begin
      bad++; $display("[TB] FAIL single_count: got=%0d want=%0d", n, N);
    end
    total++;
    if (first_v - last_acc_edge != 3) begin
      bad++; $display("[TB] FAIL single_latency: got=%0d want=3", first_v - last_acc_edge);
    end
    total++;
    if (drops != 0) begin
      bad++; $display("[TB] FAIL single_in_ready: got=%0d low cycles want=0", drops);
    end
  endtask

  task automatic test_back_to_back();
    int nb, guard, c, cyc255, cyc256;
    beat_t want;
    rdy_pct = 100; nb = 0; guard = 0; cyc255 = -1; cyc256 = -10;
    for (int f = 0; f < 4; f++) push_frame(1'b0, N);
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 3000) begin
      c = cyc;
      run_cycle();
      guard++;
      if (s_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL b2b_beat: got=%h want=no beat", s_out);
        end else begin
          want = exp_q.pop_front();
          if (s_out !== want) begin
            bad++; $display("[TB] FAIL b2b_beat[%0d]: got=%h want=%h", nb, s_out, want);
          end
        end
        if (nb == N-1) cyc255 = c;
        if (nb == N) cyc256 = c;
        nb++;
      end
    end
    total++;
    if (nb != 4*N) begin
      bad++; $display("[TB] FAIL b2b_count: got=%0d want=%0d", nb, 4*N);
    end
    total++;
    if (cyc256 != cyc255 + 1) begin
      bad++; $display("[TB] FAIL b2b_gap: got=%0d want=1", cyc256 - cyc255);
    end
  endtask

  task automatic test_backpressure();
    int nb, guard, done0, rel, nfull;
    bit exp_rdy, prev_stall;
    beat_t want, prev_out;
    rdy_pct = 30; nb = 0; guard = 0; done0 = m_done; rel = 0; prev_stall = 1'b0; prev_out = '0;
    for (int f = 0; f < 3; f++) push_frame(1'b0, N);
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 12000) begin
      nfull = (m_done - done0) - rel;
      exp_rdy = (nfull < 2);
      run_cycle();
      guard++;
      total++;
      if (s_iready !== exp_rdy) begin
        bad++; $display("[TB] FAIL bp_in_ready: got=%b want=%b banks_full=%0d", s_iready, exp_rdy, nfull);
      end
      if (prev_stall) begin
        total++;
        if (!s_ovalid || s_out !== prev_out) begin
          bad++; $display("[TB] FAIL bp_hold: got=%b/%h want=1/%h", s_ovalid, s_out, prev_out);
        end
      end
      prev_stall = s_ovalid && !s_hs;
      prev_out = s_out;
      if (s_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL bp_beat: got=%h want=no beat", s_out);
        end else begin
          want = exp_q.pop_front();
          if (s_out !== want) begin
            bad++; $display("[TB] FAIL bp_beat[%0d]: got=%h want=%h", nb, s_out, want);
          end
        end
        if (s_out.eof) rel++;
        nb++;
      end
    end
    total++;
    if (nb != 3*N) begin
      bad++; $display("[TB] FAIL bp_count: got=%0d want=%0d", nb, 3*N);
    end
  endtask

  // Partial frame of 100 samples interrupted by a new start-of-frame.
  task automatic test_misframe_sof();
    int nb, guard, errs;
    beat_t want;
    rdy_pct = 100; nb = 0; guard = 0; errs = 0;
    push_frame(1'b0, 100);
    push_frame(1'b0, N);
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
      run_cycle();
      guard++;
      if (s_err) errs++;
      if (s_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL misframe_beat: got=%h want=no beat", s_out);
        end else begin
          want = exp_q.pop_front();
          if (s_out !== want) begin
            bad++; $display("[TB] FAIL misframe_beat[%0d]: got=%h want=%h", nb, s_out, want);
          end
        end
        nb++;
      end
    end
    total++;
    if (errs != 1) begin
      bad++; $display("[TB] FAIL misframe_err: got=%0d pulses want=1", errs);
    end
    total++;
    if (nb != N) begin
      bad++; $display("[TB] FAIL misframe_count: got=%0d want=%0d", nb, N);
    end
  endtask

  // Five orphan samples before the first start-of-frame are silently dropped.
  task automatic test_misframe_nosof();
    int nb, guard, errs;
    beat_t want;
    src_t s;
    rdy_pct = 100; nb = 0; guard = 0; errs = 0;
    for (int k = 0; k < 5; k++) begin
      s.sof = 1'b0; s.r = FFT_DW'($urandom); s.i = FFT_DW'($urandom);
      src_q.push_back(s);
    end
    push_frame(1'b0, N);
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
      run_cycle();
      guard++;
      if (s_err) errs++;
      if (s_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("[TB] FAIL nosof_beat: got=%h want=no beat", s_out);
        end else begin
          want = exp_q.pop_front();
          if (s_out !== want) begin
            bad++; $display("[TB] FAIL nosof_beat[%0d]: got=%h want=%h", nb, s_out, want);
          end
        end
        nb++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("[TB] FAIL nosof_err: got=%0d pulses want=0", errs);
    end
    total++;
    if (nb != N) begin
      bad++; $display("[TB] FAIL nosof_count: got=%0d want=%0d", nb, N);
    end
  endtask

  task automatic test_reset_mid();
    int nb, guard;
    beat_t want;
    rdy_pct = 100; nb = 0; guard = 0;
    push_frame(1'b0, N);
    // Stream until the reader is near index 68, then start a second frame.
    while (nb < 68 && guard < 1000) begin
      run_cycle();
      guard++;
      if (s_hs) begin
        want = exp_q.pop_front();
        total++;
        if (s_out !== want) begin
          bad++; $display("[TB] FAIL rstmid_beat[%0d]: got=%h want=%h", nb, s_out, want);
        end
        nb++;
      end
    end
    push_frame(1'b0, 60);
    while (src_q.size() > 0 && guard < 2000) begin
      run_cycle();
      guard++;
      if (s_hs) nb++;
    end
    total++;
    if (guard >= 2000) begin
      bad++; $display("[TB] FAIL rstmid_setup: got=timeout want=progress");
    end
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_async: got=valid %b ready %b want=valid 0 ready 1", out_valid, in_ready);
    end
    exp_q.delete(); src_q.delete(); m_cnt = 0;
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    nb = 0; guard = 0;
    push_frame(1'b1, N);
    while ((src_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
      run_cycle();
      guard++;
      if (s_hs) begin
        want = {nb == 0, nb == N-1, FFT_DW'(nb), FFT_DW'(-nb)};
        total++;
        if (s_out !== want) begin
          bad++; $display("[TB] FAIL rstmid_fresh[%0d]: got=%h want=%h", nb, s_out, want);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        nb++;
      end
    end
    total++;
    if (nb != N) begin
      bad++; $display("[TB] FAIL rstmid_count: got=%0d want=%0d", nb, N);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; m_cnt = 0; m_done = 0; rdy_pct = 100;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_misframe_sof();
    test_misframe_nosof();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
